// File: rtl/phase_sequencer.sv
// ============================================================================
// Module   : phase_sequencer
// Brief    : One-hot FETCH/DECODE/EXEC/WB phase sequencer with single-step
//            and prescaled run modes, retired-instruction counter and halt.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module phase_sequencer #(
  parameter int RUN_DIV = 25_000_000,
  parameter int DIV_W   = 25,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step_pulse,
  input  logic             run_toggle,
  input  logic             halt,
  input  logic             skip_wb,
  output logic             phase_fetch,
  output logic             phase_decode,
  output logic             phase_exec,
  output logic             phase_wb,
  output logic             phase_start,
  output logic             running,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALTED = 3'd5
  } state_t;

  localparam logic [DIV_W-1:0] c_div_max = DIV_W'(RUN_DIV - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [DIV_W-1:0] r_presc;
  logic             w_tick;
  logic             w_adv;
  logic             w_retire;

  // running is already forced low in HALTED, so the tick needs no halted term
  assign w_tick = running && (r_presc == c_div_max);

  always_comb begin
    w_adv = 1'b0;
    if (r_state != S_HALTED) begin
      w_adv = running ? w_tick : (step_pulse && !run_toggle);
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_retire     = 1'b0;
    if (w_adv) begin
      case (r_state)
        S_IDLE:   w_state_next = S_FETCH;
        S_FETCH:  w_state_next = S_DECODE;
        S_DECODE: w_state_next = S_EXEC;
        S_EXEC: begin
          w_state_next = skip_wb ? S_FETCH : S_WB;
          w_retire     = skip_wb;
        end
        S_WB: begin
          w_state_next = halt ? S_HALTED : S_FETCH;
          w_retire     = 1'b1;
        end
        S_HALTED: w_state_next = S_HALTED;
        default:  w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Outputs decoded from the next state so they appear with the state itself
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_fetch  <= 1'b0;
      phase_decode <= 1'b0;
      phase_exec   <= 1'b0;
      phase_wb     <= 1'b0;
      phase_start  <= 1'b0;
      halted       <= 1'b0;
    end else begin
      phase_fetch  <= (w_state_next == S_FETCH);
      phase_decode <= (w_state_next == S_DECODE);
      phase_exec   <= (w_state_next == S_EXEC);
      phase_wb     <= (w_state_next == S_WB);
      phase_start  <= w_adv && (w_state_next != S_HALTED);
      halted       <= (w_state_next == S_HALTED);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      running <= 1'b0;
    end else if (w_state_next == S_HALTED) begin
      running <= 1'b0;
    end else if (run_toggle) begin
      running <= !running;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
    end else if (run_toggle || w_tick) begin
      r_presc <= '0;
    end else if (running) begin
      r_presc <= r_presc + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_count <= '0;
    end else if (w_retire && (instr_count != {CNT_W{1'b1}})) begin
      instr_count <= instr_count + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_phase_sequencer.sv
// ============================================================================
// Module   : tb_phase_sequencer
// Brief    : Directed self-checking bench for phase_sequencer (RUN_DIV=4, CNT_W=2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_phase_sequencer;

  logic       clk;
  logic       rst;
  logic       step_pulse;
  logic       run_toggle;
  logic       halt;
  logic       skip_wb;
  logic       phase_fetch;
  logic       phase_decode;
  logic       phase_exec;
  logic       phase_wb;
  logic       phase_start;
  logic       running;
  logic       halted;
  logic [1:0] instr_count;
  logic [3:0] ph;

  int checks = 0;
  int errors = 0;

  assign ph = {phase_fetch, phase_decode, phase_exec, phase_wb};

  phase_sequencer #(
    .RUN_DIV (4),
    .DIV_W   (2),
    .CNT_W   (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .step_pulse   (step_pulse),
    .run_toggle   (run_toggle),
    .halt         (halt),
    .skip_wb      (skip_wb),
    .phase_fetch  (phase_fetch),
    .phase_decode (phase_decode),
    .phase_exec   (phase_exec),
    .phase_wb     (phase_wb),
    .phase_start  (phase_start),
    .running      (running),
    .halted       (halted),
    .instr_count  (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
    step_pulse = 1'b1;
    @(negedge clk);
    step_pulse = 1'b0;
  endtask

  task automatic toggle();
    @(negedge clk);
    run_toggle = 1'b1;
    @(negedge clk);
    run_toggle = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (ph !== 4'b0000 || phase_start !== 1'b0 || running !== 1'b0 ||
        halted !== 1'b0 || instr_count !== 2'd0) begin
      errors++;
      $display("FAIL reset: ph=%b start=%b run=%b halted=%b cnt=%0d, want 0000/0/0/0/0",
               ph, phase_start, running, halted, instr_count);
    end
  endtask

  task automatic test_step_sequence();
    logic [3:0] exp_ph [5];
    exp_ph = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (ph !== exp_ph[i] || phase_start !== 1'b1) begin
        errors++;
        $display("FAIL step_phase[%0d]: ph=%b start=%b, want %b/1", i, ph, phase_start, exp_ph[i]);
      end
      @(negedge clk);
      checks++;
      if (ph !== exp_ph[i] || phase_start !== 1'b0) begin
        errors++;
        $display("FAIL step_hold[%0d]: ph=%b start=%b, want %b/0", i, ph, phase_start, exp_ph[i]);
      end
      if (i == 3) begin
        checks++;
        if (instr_count !== 2'd0) begin
          errors++;
          $display("FAIL step_count_wb: cnt=%0d, want 0", instr_count);
        end
      end
    end
    checks++;
    if (instr_count !== 2'd1) begin
      errors++;
      $display("FAIL step_count: cnt=%0d, want 1", instr_count);
    end
  endtask

  task automatic test_skip_wb();
    step();
    step();
    checks++;
    if (ph !== 4'b0010) begin
      errors++;
      $display("FAIL skip_exec: ph=%b, want 0010", ph);
    end
    skip_wb = 1'b1;
    step();
    skip_wb = 1'b0;
    checks++;
    if (ph !== 4'b1000 || instr_count !== 2'd2) begin
      errors++;
      $display("FAIL skip_fetch: ph=%b cnt=%0d, want 1000/2", ph, instr_count);
    end
    step();
    checks++;
    if (ph !== 4'b0100) begin
      errors++;
      $display("FAIL skip_decode: ph=%b, want 0100", ph);
    end
  endtask

  task automatic test_run_mode();
    logic [3:0] exp_ph [4];
    logic [3:0] e;
    exp_ph = '{4'b0000, 4'b1000, 4'b0100, 4'b0010};
    do_reset();
    toggle();
    checks++;
    if (running !== 1'b1) begin
      errors++;
      $display("FAIL run_on: running=%b, want 1", running);
    end
    step_pulse = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      e = exp_ph[k / 4];
      checks++;
      if (ph !== e || phase_start !== ((k % 4) == 0)) begin
        errors++;
        $display("FAIL run_cycle[%0d]: ph=%b start=%b, want %b/%0d", k, ph, phase_start, e, (k % 4) == 0);
      end
    end
    step_pulse = 1'b0;
    toggle();
    checks++;
    if (running !== 1'b0 || ph !== 4'b0010) begin
      errors++;
      $display("FAIL run_off: running=%b ph=%b, want 0/0010", running, ph);
    end
    repeat (6) @(negedge clk);
    checks++;
    if (ph !== 4'b0010) begin
      errors++;
      $display("FAIL run_frozen: ph=%b, want 0010", ph);
    end
    toggle();
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      e = (k == 4) ? 4'b0001 : 4'b0010;
      checks++;
      if (ph !== e) begin
        errors++;
        $display("FAIL run_resume[%0d]: ph=%b, want %b", k, ph, e);
      end
    end
    toggle();
  endtask

  task automatic test_halt();
    do_reset();
    halt = 1'b1;
    toggle();
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 16) begin
        checks++;
        if (ph !== 4'b0001) begin
          errors++;
          $display("FAIL halt_wb: ph=%b, want 0001", ph);
        end
      end
    end
    checks++;
    if (ph !== 4'b0000 || halted !== 1'b1 || running !== 1'b0 ||
        instr_count !== 2'd1 || phase_start !== 1'b0) begin
      errors++;
      $display("FAIL halt_enter: ph=%b halted=%b run=%b cnt=%0d start=%b, want 0000/1/0/1/0",
               ph, halted, running, instr_count, phase_start);
    end
    halt = 1'b0;
    step();
    toggle();
    repeat (8) @(negedge clk);
    checks++;
    if (ph !== 4'b0000 || halted !== 1'b1 || running !== 1'b0 || instr_count !== 2'd1) begin
      errors++;
      $display("FAIL halt_sticky: ph=%b halted=%b run=%b cnt=%0d, want 0000/1/0/1",
               ph, halted, running, instr_count);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    toggle();
    repeat (13) @(negedge clk);
    checks++;
    if (ph !== 4'b0010 || running !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre: ph=%b run=%b, want 0010/1", ph, running);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (ph !== 4'b0000 || phase_start !== 1'b0 || running !== 1'b0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL areset_async: ph=%b start=%b run=%b halted=%b, want 0000/0/0/0",
               ph, phase_start, running, halted);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (ph !== 4'b0000 || running !== 1'b0) begin
      errors++;
      $display("FAIL areset_idle: ph=%b run=%b, want 0000/0", ph, running);
    end
    step();
    checks++;
    if (ph !== 4'b1000 || phase_start !== 1'b1) begin
      errors++;
      $display("FAIL areset_fetch: ph=%b start=%b, want 1000/1", ph, phase_start);
    end
  endtask

  task automatic test_saturation_and_same_cycle();
    do_reset();
    skip_wb = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      if (i == 4) begin
        checks++;
        if (instr_count !== 2'd1) begin
          errors++;
          $display("FAIL sat_first: cnt=%0d, want 1", instr_count);
        end
      end
      if (i == 10 || i == 13 || i == 16) begin
        checks++;
        if (instr_count !== 2'd3) begin
          errors++;
          $display("FAIL sat_hold[%0d]: cnt=%0d, want 3", i, instr_count);
        end
      end
    end
    skip_wb = 1'b0;
    @(negedge clk);
    step_pulse = 1'b1;
    run_toggle = 1'b1;
    @(negedge clk);
    step_pulse = 1'b0;
    run_toggle = 1'b0;
    checks++;
    if (running !== 1'b1 || ph !== 4'b1000 || phase_start !== 1'b0) begin
      errors++;
      $display("FAIL same_cycle: run=%b ph=%b start=%b, want 1/1000/0", running, ph, phase_start);
    end
    toggle();
    checks++;
    if (running !== 1'b0 || ph !== 4'b1000) begin
      errors++;
      $display("FAIL same_cycle_off: run=%b ph=%b, want 0/1000", running, ph);
    end
  endtask

  initial begin
    rst        = 1'b1;
    step_pulse = 1'b0;
    run_toggle = 1'b0;
    halt       = 1'b0;
    skip_wb    = 1'b0;
    test_reset();
    test_step_sequence();
    test_skip_wb();
    test_run_mode();
    test_halt();
    test_async_reset();
    test_saturation_and_same_cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
